// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard unit: operand forwarding, load-use stall,
//               branch flush and multi-cycle mul/div hold with timeout abort.
//               Optional macro HAZARD_PERF_EN adds stall/flush cycle counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int MD_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic [1:0]  ResultSrcE,
    input  logic        PCSrcE,
    input  logic        mdStartE,
    input  logic        mdDone,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushM,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        mdBusy,
    output logic        mdErr
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stallCnt,
    output logic [31:0] flushCnt
`endif
);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] c_WAIT_LAST = 8'(MD_TIMEOUT - 1);

    state_t     r_state;
    logic [7:0] r_wait_cnt;
    logic       r_md_err;

    logic       w_lw_stall;
    logic       w_md_enter;
    logic       w_timeout;
    logic       w_md_hold;

    assign w_lw_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                        ((RdE == Rs1D) || (RdE == Rs2D));

    // A branch in the same cycle wins over starting a multi-cycle op.
    assign w_md_enter = (r_state == RUN) && mdStartE && !mdDone && !PCSrcE;
    assign w_timeout  = (r_state == MD_WAIT) && !mdDone && (r_wait_cnt == c_WAIT_LAST);
    assign w_md_hold  = w_md_enter ||
                        ((r_state == MD_WAIT) && !mdDone && !w_timeout);

    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (!rst) begin
            if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))
                ForwardAE = 2'b10;
            else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E))
                ForwardAE = 2'b01;
            if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))
                ForwardBE = 2'b10;
            else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E))
                ForwardBE = 2'b01;
        end
    end

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushM = 1'b0;
        if (rst) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushM = 1'b1;
        end else if (w_md_hold) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
        end else begin
            StallF = w_lw_stall;
            StallD = w_lw_stall;
            FlushD = PCSrcE;
            FlushE = w_lw_stall || PCSrcE || w_timeout;
        end
    end

    assign mdBusy = !rst && (r_state == MD_WAIT);
    assign mdErr  = r_md_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RUN;
            r_wait_cnt <= 8'd0;
            r_md_err   <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_md_enter) begin
                        r_state    <= MD_WAIT;
                        r_wait_cnt <= 8'd0;
                    end
                end
                MD_WAIT: begin
                    if (mdDone) begin
                        r_state <= RUN;
                    end else if (w_timeout) begin
                        r_state  <= RUN;
                        r_md_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (StallF && (r_stall_cnt != 32'hFFFF_FFFF))
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (FlushE && (r_flush_cnt != 32'hFFFF_FFFF))
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign stallCnt = r_stall_cnt;
    assign flushCnt = r_flush_cnt;
`endif

endmodule
`default_nettype wire
